pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Parametrised pipeline tracking, forwarding and interlock unit for the CPU datapath.
- Holds per-stage destination tag, valid and result for DEPTH stages after decode (stage 1 = EX ... stage DEPTH = WB).
- Drives forwarded A/B operands into decode and load-use stall, branch flush and register-file write.
- Replaces the hard-coded single-stage forwarding, one-shot stall and flush logic, and adds stall/flush performance counters.

Parameters:
- DATA_W, 32, operand/result width.
- REG_AW, 5, register address width.
- DEPTH, 3, tracked stages after decode (legal 2..8).
- LOAD_STAGE, 2, stage whose entry receives mem_rdata (1 <= LOAD_STAGE < DEPTH).
- BR_STAGE, 2, stage where branch outcome is valid (1..DEPTH).
- ZERO_REG, 1, if 1 register 0 is never forwarded, stalled on, or written.

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  synchronous, active-high.
- hold  in  1  external freeze (memory wait); no state changes except counters.
- id_valid  in  1  decode slot holds an instruction.
- id_src_a  in  REG_AW  A source register.
- id_src_b  in  REG_AW  B source register.
- id_use_b  in  1  B operand is a register (not literal).
- id_rd  in  REG_AW  destination register.
- id_we  in  1  instruction writes back.
- id_load  in  1  instruction is a load.
- rf_rdata_a  in  DATA_W  register file A read.
- rf_rdata_b  in  DATA_W  register file B read.
- ex_result  in  DATA_W  ALU result for the instruction entering stage 1.
- mem_rdata  in  DATA_W  load data for the load in stage LOAD_STAGE.
- br_taken  in  1  branch in stage BR_STAGE is taken.
- op_a  out  DATA_W  resolved A operand.
- op_b  out  DATA_W  resolved B operand.
- stall_o  out  1  hold fetch/decode this cycle.
- flush_o  out  1  kill fetch/decode contents this cycle.
- rf_we  out  1  register write enable.
- rf_waddr  out  REG_AW  write address.
- rf_wdata  out  DATA_W  write data.
- stall_cnt  out  32  saturating count of stall cycles.
- flush_cnt  out  32  saturating count of flush events.

Behaviour:
- Per stage k: v[k], rd[k], we[k], ld[k], rdy[k], res[k].
- Reset: all v=0, counters=0; hence stall_o=flush_o=rf_we=0. Reset mid-operation discards all in-flight entries in one cycle.
- Advance, when ~hold: entry k moves to k+1; entry DEPTH retires.
- Entry into stage 1: res=ex_result, rdy=~id_load.
- Entry into stage LOAD_STAGE+1 from a valid load: res=mem_rdata, rdy=1.
- Forwarding, per operand independently, combinational:
  - Search stages 1..DEPTH, youngest first; a match is v & we & rd==src & ~(ZERO_REG & src==0).
  - First match with rdy: use its res. No match: use rf_rdata.
  - First match not rdy (load at stage <= LOAD_STAGE) is a hazard. B is checked only if id_use_b.
- flush_o = v[BR_STAGE] & br_taken & ~hold.
- stall_o = id_valid & hazard & ~flush_o.
- Flush takes priority over stall.
- On a flush edge, stages 1..BR_STAGE load v=0; older entries advance normally.
- On a stall edge, stage 1 loads a bubble (v=0) and stages 2..DEPTH advance. Upstream keeps id_* stable.
- rf_we = v[DEPTH] & we[DEPTH] & ~hold & ~(ZERO_REG & rd[DEPTH]==0). rf_waddr/rf_wdata come from stage DEPTH.
- WB-to-decode same-cycle reads are covered by the forwarding search, which includes stage DEPTH.
- hold=1: pipeline frozen, flush_o=0 and rf_we=0. stall_o still reflects the hazard. Counters do not increment.
- stall_cnt increments on each edge with stall_o & ~hold. flush_cnt increments on each edge with flush_o. Both saturate at 0xFFFFFFFF with no wrap.
- Latency: ex_result written to the register file DEPTH cycles after issue. A load-use gap of g stages stalls max(0, LOAD_STAGE-g+1) cycles.

Test Plan:
- Defaults, back-to-back ALU ops: "r3=5" then "use r3" -> op_a=5 forwarded from stage 1, stall_o=0, rf_we for r3 two cycles later.
- Load r4 (mem_rdata=0xDEAD) immediately followed by "use r4" -> stall_o high 2 cycles, then op_a=0xDEAD; stall_cnt=2.
- Taken branch in stage 2 with two younger valid entries -> flush_o one cycle; those entries never reach rf_we; flush_cnt=1; concurrent hazard suppresses stall_o.
- Write to r0 with ZERO_REG=1, then use r0 -> op_a=rf_rdata_a, rf_we=0.
- hold for 3 cycles mid-pipeline with a hazard pending -> no advance, rf_we=0, stall_cnt unchanged; resumes with identical results.
- Reset asserted with full pipe -> next cycle all outputs 0, counters 0; DEPTH=5, LOAD_STAGE=3 rerun shows a 3-cycle load-use stall.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline tracking, forwarding and interlock unit.
// Tracks DEPTH stages after decode (stage 1 = EX ... stage DEPTH = WB), resolves
// decode operands from in-flight results, raises load-use stall and branch
// flush, drives the register-file write port, and counts stalls/flushes.
module pipe_hazard_ctrl #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned REG_AW     = 5,
  parameter int unsigned DEPTH      = 3,
  parameter int unsigned LOAD_STAGE = 2,
  parameter int unsigned BR_STAGE   = 2,
  parameter int unsigned ZERO_REG   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              hold,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_src_a,
  input  logic [REG_AW-1:0] id_src_b,
  input  logic              id_use_b,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_we,
  input  logic              id_load,
  input  logic [DATA_W-1:0] rf_rdata_a,
  input  logic [DATA_W-1:0] rf_rdata_b,
  input  logic [DATA_W-1:0] ex_result,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              br_taken,
  output logic [DATA_W-1:0] op_a,
  output logic [DATA_W-1:0] op_b,
  output logic              stall_o,
  output logic              flush_o,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       flush_cnt
);

  logic              v   [1:DEPTH];
  logic [REG_AW-1:0] rd  [1:DEPTH];
  logic              we  [1:DEPTH];
  logic              ld  [1:DEPTH];
  logic              rdy [1:DEPTH];
  logic [DATA_W-1:0] res [1:DEPTH];

  logic zero_a, zero_b;
  logic found_a, found_b;
  logic haz_a, haz_b;

  assign zero_a = (ZERO_REG != 0) && (id_src_a == '0);
  assign zero_b = (ZERO_REG != 0) && (id_src_b == '0);

  // Operand resolution: the youngest matching writer decides the operand or the hazard
  always_comb begin
    op_a    = rf_rdata_a;
    op_b    = rf_rdata_b;
    found_a = 1'b0;
    found_b = 1'b0;
    haz_a   = 1'b0;
    haz_b   = 1'b0;
    for (int unsigned k = 1; k <= DEPTH; k++) begin
      if (!found_a && v[k] && we[k] && (rd[k] == id_src_a) && !zero_a) begin
        found_a = 1'b1;
        if (rdy[k]) op_a = res[k];
        else        haz_a = 1'b1;
      end
      if (!found_b && v[k] && we[k] && (rd[k] == id_src_b) && !zero_b) begin
        found_b = 1'b1;
        if (rdy[k]) op_b = res[k];
        else        haz_b = 1'b1;
      end
    end
  end

  assign flush_o  = v[BR_STAGE] & br_taken & ~hold;
  assign stall_o  = id_valid & (haz_a | (id_use_b & haz_b)) & ~flush_o;
  assign rf_we    = v[DEPTH] & we[DEPTH] & ~hold &
                    ~((ZERO_REG != 0) && (rd[DEPTH] == '0));
  assign rf_waddr = rd[DEPTH];
  assign rf_wdata = res[DEPTH];

  // Stage advance: flush kills stages 1..BR_STAGE, stall injects a bubble into stage 1,
  // and the load-return stage picks up mem_rdata for a valid load
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned k = 1; k <= DEPTH; k++) begin
        v[k]   <= 1'b0;
        rd[k]  <= '0;
        we[k]  <= 1'b0;
        ld[k]  <= 1'b0;
        rdy[k] <= 1'b0;
        res[k] <= '0;
      end
    end else if (!hold) begin
      v[1]   <= id_valid & ~flush_o & ~stall_o;
      rd[1]  <= id_rd;
      we[1]  <= id_we;
      ld[1]  <= id_load;
      rdy[1] <= ~id_load;
      res[1] <= ex_result;
      for (int unsigned k = 2; k <= DEPTH; k++) begin
        v[k]  <= v[k-1] & ~(flush_o && (k <= BR_STAGE));
        rd[k] <= rd[k-1];
        we[k] <= we[k-1];
        ld[k] <= ld[k-1];
        if ((k == LOAD_STAGE + 1) && v[k-1] && ld[k-1]) begin
          res[k] <= mem_rdata;
          rdy[k] <= 1'b1;
        end else begin
          res[k] <= res[k-1];
          rdy[k] <= rdy[k-1];
        end
      end
    end
  end

  // Saturating stall/flush performance counters
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_o && !hold && (stall_cnt != '1)) stall_cnt <= stall_cnt + 32'd1;
      if (flush_o && (flush_cnt != '1))          flush_cnt <= flush_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomized bench for pipe_hazard_ctrl against a queue-based reference model,
// followed by a directed load-use run on a default and a DEPTH=5/LOAD_STAGE=3 instance.
module tb_pipe_hazard_ctrl;

  localparam int unsigned D  = 3;
  localparam int unsigned LS = 2;
  localparam int unsigned BR = 2;

  logic        clk = 1'b0;
  logic        reset, hold, id_valid, id_use_b, id_we, id_load, br_taken;
  logic [4:0]  id_src_a, id_src_b, id_rd;
  logic [31:0] rf_rdata_a, rf_rdata_b, ex_result, mem_rdata;

  logic [31:0] op_a, op_b, rf_wdata, stall_cnt, flush_cnt;
  logic        stall_o, flush_o, rf_we;
  logic [4:0]  rf_waddr;

  logic [31:0] op_a1, op_b1, rf_wdata1, stall_cnt1, flush_cnt1;
  logic        stall_o1, flush_o1, rf_we1;
  logic [4:0]  rf_waddr1;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.DATA_W(32), .REG_AW(5), .DEPTH(D), .LOAD_STAGE(LS),
                     .BR_STAGE(BR), .ZERO_REG(1)) u0 (
    .clk(clk), .reset(reset), .hold(hold), .id_valid(id_valid),
    .id_src_a(id_src_a), .id_src_b(id_src_b), .id_use_b(id_use_b),
    .id_rd(id_rd), .id_we(id_we), .id_load(id_load),
    .rf_rdata_a(rf_rdata_a), .rf_rdata_b(rf_rdata_b), .ex_result(ex_result),
    .mem_rdata(mem_rdata), .br_taken(br_taken), .op_a(op_a), .op_b(op_b),
    .stall_o(stall_o), .flush_o(flush_o), .rf_we(rf_we), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt));

  pipe_hazard_ctrl #(.DATA_W(32), .REG_AW(5), .DEPTH(5), .LOAD_STAGE(3),
                     .BR_STAGE(2), .ZERO_REG(1)) u1 (
    .clk(clk), .reset(reset), .hold(hold), .id_valid(id_valid),
    .id_src_a(id_src_a), .id_src_b(id_src_b), .id_use_b(id_use_b),
    .id_rd(id_rd), .id_we(id_we), .id_load(id_load),
    .rf_rdata_a(rf_rdata_a), .rf_rdata_b(rf_rdata_b), .ex_result(ex_result),
    .mem_rdata(mem_rdata), .br_taken(br_taken), .op_a(op_a1), .op_b(op_b1),
    .stall_o(stall_o1), .flush_o(flush_o1), .rf_we(rf_we1), .rf_waddr(rf_waddr1),
    .rf_wdata(rf_wdata1), .stall_cnt(stall_cnt1), .flush_cnt(flush_cnt1));

  // In-flight instruction record; queue index 0 is the youngest (stage 1)
  typedef struct {
    bit        v;
    bit [4:0]  rd;
    bit        we;
    bit        ld;
    bit        known;
    bit [31:0] val;
  } rec_t;

  rec_t        pipe[$];
  int unsigned m_stall, m_flush;
  int unsigned checks, errors;
  bit          have_model;
  bit          e_stall, e_flush;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Youngest in-flight writer of src supplies the value; an unreturned load is a hazard
  function automatic void lookup(input bit [4:0] src, input bit [31:0] rf,
                                 output bit haz, output bit [31:0] val);
    haz = 1'b0;
    val = rf;
    if (src == 5'd0) return;
    foreach (pipe[i]) begin
      if (pipe[i].v && pipe[i].we && pipe[i].rd == src) begin
        if (pipe[i].known) val = pipe[i].val;
        else               haz = 1'b1;
        return;
      end
    end
  endfunction

  task automatic check_outputs();
    bit        ha, hb, e_we;
    bit [31:0] va, vb;
    rec_t      last;
    lookup(id_src_a, rf_rdata_a, ha, va);
    lookup(id_src_b, rf_rdata_b, hb, vb);
    e_flush = pipe[BR-1].v && br_taken && !hold;
    e_stall = id_valid && (ha || (id_use_b && hb)) && !e_flush;
    last    = pipe[D-1];
    e_we    = last.v && last.we && !hold && (last.rd != 5'd0);
    chk("flush_o", flush_o, e_flush);
    chk("stall_o", stall_o, e_stall);
    chk("rf_we", rf_we, e_we);
    if (e_we) begin
      chk("rf_waddr", rf_waddr, last.rd);
      chk("rf_wdata", rf_wdata, last.val);
    end
    if (!ha) chk("op_a", op_a, va);
    if (!hb) chk("op_b", op_b, vb);
    chk("stall_cnt", stall_cnt, m_stall);
    chk("flush_cnt", flush_cnt, m_flush);
  endtask

  task automatic model_update();
    rec_t nr, bub;
    bub = '{default: 0};
    if (reset) begin
      pipe.delete();
      repeat (D) pipe.push_back(bub);
      m_stall    = 0;
      m_flush    = 0;
      have_model = 1'b1;
    end else if (have_model && !hold) begin
      if (e_stall && m_stall != 32'hFFFF_FFFF) m_stall++;
      if (e_flush && m_flush != 32'hFFFF_FFFF) m_flush++;
      if (pipe[LS-1].v && pipe[LS-1].ld) begin
        pipe[LS-1].known = 1'b1;
        pipe[LS-1].val   = mem_rdata;
      end
      if (e_flush) for (int i = 0; i < int'(BR) - 1; i++) pipe[i].v = 1'b0;
      void'(pipe.pop_back());
      nr = bub;
      if (id_valid && !e_flush && !e_stall)
        nr = '{1'b1, id_rd, id_we, id_load, !id_load, ex_result};
      pipe.push_front(nr);
    end
  endtask

  // Inputs are already driven at the falling edge; check, clock, update model
  task automatic step();
    #1;
    if (have_model) check_outputs();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic drive_random(input bit keep_id);
    reset      = ($urandom_range(99) == 0);
    hold       = ($urandom_range(6) == 0);
    br_taken   = ($urandom_range(5) == 0);
    rf_rdata_a = $urandom;
    rf_rdata_b = $urandom;
    ex_result  = $urandom;
    mem_rdata  = $urandom;
    if (!keep_id) begin
      id_valid = ($urandom_range(4) != 0);
      id_src_a = 5'($urandom_range(7));
      id_src_b = 5'($urandom_range(7));
      id_rd    = 5'($urandom_range(7));
      id_we    = ($urandom_range(3) != 0);
      id_load  = ($urandom_range(2) == 0);
      id_use_b = 1'($urandom_range(1));
    end
  endtask

  initial begin
    int unsigned n0, n1;
    bit          got0, got1, keep;
    reset = 1'b1; hold = 1'b0; br_taken = 1'b0; id_valid = 1'b0;
    id_src_a = '0; id_src_b = '0; id_rd = '0; id_we = 1'b0; id_load = 1'b0;
    id_use_b = 1'b0; rf_rdata_a = '0; rf_rdata_b = '0; ex_result = '0; mem_rdata = '0;
    checks = 0; errors = 0; have_model = 1'b0; e_stall = 1'b0; e_flush = 1'b0;
    @(negedge clk);
    step();
    reset = 1'b0;
    #1;
    chk("rst_stall_cnt", stall_cnt, 0);
    chk("rst_flush_cnt", flush_cnt, 0);
    chk("rst_rf_we", rf_we, 0);

    for (int c = 0; c < 4000; c++) begin
      keep = (c != 0) && (e_stall || hold) && !reset;
      drive_random(keep);
      step();
    end

    // Directed load-use on both instances
    reset = 1'b1; hold = 1'b0; br_taken = 1'b0; id_valid = 1'b0;
    mem_rdata = 32'hDEAD; ex_result = 32'h1111;
    rf_rdata_a = 32'h5555; rf_rdata_b = 32'h6666;
    step();
    reset = 1'b0;
    #1;
    chk("rst_stall_cnt1", stall_cnt1, 0);
    chk("rst_flush_cnt1", flush_cnt1, 0);
    id_valid = 1'b1; id_rd = 5'd4; id_we = 1'b1; id_load = 1'b1;
    id_src_a = 5'd1; id_src_b = 5'd2; id_use_b = 1'b0;
    step();
    id_rd = 5'd9; id_load = 1'b0; id_src_a = 5'd4;
    n0 = 0; n1 = 0; got0 = 1'b0; got1 = 1'b0;
    for (int i = 0; i < 12; i++) begin
      #1;
      if (stall_o) n0++;
      else if (!got0) begin got0 = 1'b1; chk("u0_fwd_load", op_a, 32'hDEAD); end
      if (stall_o1) n1++;
      else if (!got1) begin got1 = 1'b1; chk("u1_fwd_load", op_a1, 32'hDEAD); end
      step();
    end
    chk("u0_stall_cycles", n0, 2);
    chk("u1_stall_cycles", n1, 3);
    chk("u0_stall_cnt", stall_cnt, 2);
    chk("u1_stall_cnt", stall_cnt1, 3);
    chk("u1_flush_cnt", flush_cnt1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
